// File: rtl/proc_dpath_muldiv.sv
// Iterative unsigned multiply/divide unit for the X stage: MUL, MULHU, DIVU and REMU
// behind val/rdy handshakes, one shift-add or restoring-divide step per CALC cycle.
module proc_dpath_muldiv #(
  parameter int p_nbits      = 32,
  parameter bit p_early_exit = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [1:0]         req_msg_fn,
  input  logic [p_nbits-1:0] req_msg_a,
  input  logic [p_nbits-1:0] req_msg_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg,
  output logic               busy
);

  localparam int N  = p_nbits;
  localparam int CW = $clog2(p_nbits);

  localparam logic [1:0] FN_MUL   = 2'd0;
  localparam logic [1:0] FN_MULHU = 2'd1;
  localparam logic [1:0] FN_DIVU  = 2'd2;
  localparam logic [1:0] FN_REMU  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     fn_q, fn_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           resp_val_q, resp_val_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   resp_msg_q, resp_msg_d;

  // quot_q doubles as the multiplier register (MUL*) and the dividend/quotient (DIV*).
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N:0]     rem_q, rem_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic           dbz_q, dbz_d;

  logic [2*N-1:0] acc_step;
  logic [N-1:0]   mplier_step;
  logic [N+1:0]   diff;
  logic [N:0]     rem_step;
  logic [N-1:0]   quot_step;
  logic           is_mul;
  logic           last;
  logic [N-1:0]   result;

  assign req_rdy  = (state_q == S_IDLE) && !reset;
  assign resp_val = resp_val_q;
  assign busy     = busy_q;
  assign resp_msg = resp_msg_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    fn_d       = fn_q;
    cnt_d      = cnt_q;
    resp_val_d = resp_val_q;
    busy_d     = busy_q;
    resp_msg_d = resp_msg_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    dbz_d      = dbz_q;

    acc_step    = quot_q[0] ? acc_q + mcand_q : acc_q;
    mplier_step = quot_q >> 1;

    // The top bit of the N+2 bit difference is the borrow of the trial subtraction.
    diff = {rem_q, quot_q[N-1]} - {2'b00, dvsr_q};
    if (diff[N+1]) begin
      rem_step  = {rem_q[N-1:0], quot_q[N-1]};
      quot_step = {quot_q[N-2:0], 1'b0};
    end else begin
      rem_step  = diff[N:0];
      quot_step = {quot_q[N-2:0], 1'b1};
    end

    is_mul = !fn_q[1];
    last   = (cnt_q == CW'(N-1))
          || (p_early_exit && is_mul && (mplier_step == '0))
          || (!is_mul && dbz_q);

    unique case (fn_q)
      FN_MUL:   result = acc_step[N-1:0];
      FN_MULHU: result = acc_step[2*N-1:N];
      FN_DIVU:  result = dbz_q ? '1 : quot_step;
      FN_REMU:  result = dbz_q ? quot_q : rem_step[N-1:0];
      default:  result = '0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (req_val && req_rdy) begin
          state_d = S_CALC;
          fn_d    = req_msg_fn;
          cnt_d   = '0;
          busy_d  = 1'b1;
          acc_d   = '0;
          mcand_d = {{N{1'b0}}, req_msg_a};
          quot_d  = req_msg_fn[1] ? req_msg_a : req_msg_b;
          rem_d   = '0;
          dvsr_d  = req_msg_b;
          dbz_d   = (req_msg_b == '0);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mul) begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          quot_d  = mplier_step;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
        end
        if (last) begin
          state_d    = S_DONE;
          resp_val_d = 1'b1;
          resp_msg_d = result;
        end
      end
      S_DONE: begin
        if (resp_rdy) begin
          state_d    = S_IDLE;
          resp_val_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fn_q       <= FN_MUL;
      cnt_q      <= '0;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      fn_q       <= fn_d;
      cnt_q      <= cnt_d;
      resp_val_q <= resp_val_d;
      busy_q     <= busy_d;
      resp_msg_q <= resp_msg_d;
    end
  end

  // NOTE: datapath registers need no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    quot_q  <= quot_d;
    rem_q   <= rem_d;
    dvsr_q  <= dvsr_d;
    dbz_q   <= dbz_d;
  end

endmodule

// File: tb/tb_proc_dpath_muldiv.sv
// Bench for proc_dpath_muldiv: directed cases plus random operations against an
// arithmetic reference model; one unit with early exit, one without.
module tb_proc_dpath_muldiv;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_val;
  logic         sel;
  logic [1:0]   fn;
  logic [N-1:0] a, b;
  logic         resp_rdy;

  logic         rr0, rv0, bz0, rr1, rv1, bz1;
  logic [N-1:0] rm0, rm1;
  logic         req_rdy_o, resp_val_o, busy_o;
  logic [N-1:0] resp_msg_o;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  proc_dpath_muldiv #(.p_nbits(N), .p_early_exit(1'b1)) dut (
    .clk(clk), .reset(reset), .req_val(req_val && !sel), .req_rdy(rr0),
    .req_msg_fn(fn), .req_msg_a(a), .req_msg_b(b),
    .resp_val(rv0), .resp_rdy(resp_rdy), .resp_msg(rm0), .busy(bz0)
  );

  proc_dpath_muldiv #(.p_nbits(N), .p_early_exit(1'b0)) dut_ne (
    .clk(clk), .reset(reset), .req_val(req_val && sel), .req_rdy(rr1),
    .req_msg_fn(fn), .req_msg_a(a), .req_msg_b(b),
    .resp_val(rv1), .resp_rdy(resp_rdy), .resp_msg(rm1), .busy(bz1)
  );

  assign req_rdy_o  = sel ? rr1 : rr0;
  assign resp_val_o = sel ? rv1 : rv0;
  assign busy_o     = sel ? bz1 : bz0;
  assign resp_msg_o = sel ? rm1 : rm0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_result(input logic [1:0] f, input logic [N-1:0] x, y);
    logic [2*N-1:0] p;
    p = 64'(x) * 64'(y);
    case (f)
      2'd0:    return p[N-1:0];
      2'd1:    return p[2*N-1:N];
      2'd2:    return (y == 0) ? {N{1'b1}} : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycles from the edge opening the handshake cycle to the first cycle with resp_val high.
  function automatic int ref_lat(input logic [1:0] f, input logic [N-1:0] y, input bit early);
    int k;
    if (f[1])  return (y == 0) ? 2 : N + 1;
    if (!early) return N + 1;
    k = 1;
    for (int i = 0; i < N; i++) if (y[i]) k = i + 1;
    return k + 1;
  endfunction

  // Called #1 after a rising edge; returns in the first cycle showing resp_val.
  task automatic op(input string tag, input logic [1:0] f, input logic [N-1:0] x, y,
                    output logic [N-1:0] got, output int lat);
    int guard;
    fn = f; a = x; b = y; req_val = 1'b1;
    guard = 0;
    while (!req_rdy_o && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      req_val = 1'b0; got = '0; lat = 0;
      return;
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    lat = 1;
    while (!resp_val_o && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_val_o) chk({tag, "_resp_timeout"}, 0, 1);
    got = resp_msg_o;
  endtask

  task automatic run(input string tag, input logic s, input logic [1:0] f,
                     input logic [N-1:0] x, y);
    logic [N-1:0] got;
    int lat;
    sel = s;
    op(tag, f, x, y, got, lat);
    chk({tag, "_res"}, got, ref_result(f, x, y));
    chk({tag, "_lat"}, lat, ref_lat(f, y, !s));
    @(posedge clk); #1;
    chk({tag, "_ack"}, resp_val_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] got, x, y;
    logic [1:0]   f;
    int           lat;

    reset = 1'b1; req_val = 1'b0; sel = 1'b0; resp_rdy = 1'b1;
    fn = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_val", resp_val_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp_msg", resp_msg_o, 0);
    chk("rst_req_rdy_low", req_rdy_o, 0);
    reset = 1'b0;
    #1;
    chk("rst_req_rdy_high", req_rdy_o, 1);

    run("mul_7x6", 1'b0, 2'd0, 32'd7, 32'd6);
    run("mulhu_ff", 1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mul_ff", 1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mul_b0", 1'b0, 2'd0, 32'd123, 32'd0);
    run("mul_ne_3x1", 1'b1, 2'd0, 32'd3, 32'd1);
    run("divu_100_7", 1'b0, 2'd2, 32'd100, 32'd7);
    run("remu_100_7", 1'b0, 2'd3, 32'd100, 32'd7);
    run("divu_ff_1", 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1);
    run("divu_5_0", 1'b0, 2'd2, 32'd5, 32'd0);
    run("remu_5_0", 1'b0, 2'd3, 32'd5, 32'd0);

    // Backpressure with a request queued while the response is held.
    sel = 1'b0;
    resp_rdy = 1'b0;
    op("bp_mul", 2'd0, 32'd3, 32'd5, got, lat);
    chk("bp_mul_res", got, 15);
    chk("bp_mul_lat", lat, 4);
    fn = 2'd2; a = 32'd9; b = 32'd2; req_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_msg", resp_msg_o, 15);
      chk("bp_hold_val", resp_val_o, 1);
      chk("bp_hold_rdy", req_rdy_o, 0);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_ack_val", resp_val_o, 0);
    chk("bp_ack_busy", busy_o, 0);
    chk("bp_ack_rdy", req_rdy_o, 1);
    @(posedge clk); #1;
    req_val = 1'b0;
    chk("bp_q_busy", busy_o, 1);
    lat = 1;
    while (!resp_val_o && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_q_res", resp_msg_o, 4);
    chk("bp_q_lat", lat, N + 1);
    @(posedge clk); #1;

    // Reset in the middle of a divide.
    fn = 2'd2; a = 32'd1000; b = 32'd3; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rmid_busy_before", busy_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmid_resp_val", resp_val_o, 0);
    chk("rmid_busy", busy_o, 0);
    chk("rmid_req_rdy_low", req_rdy_o, 0);
    reset = 1'b0;
    #1;
    chk("rmid_req_rdy_high", req_rdy_o, 1);
    run("rmid_mul_2x2", 1'b0, 2'd0, 32'd2, 32'd2);

    for (int i = 0; i < 48; i++) begin
      f = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'($urandom_range(0, 255));
        1:       y = '0;
        2:       y = '1;
        3:       y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      run("rand", (i % 6) == 5, f, x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
